pen_locator: RTL
================

Name: pen_locator

Overview:
- Resolves the light-pen position on the 8x8 LED matrix.
- Correlates the pen photodiode pulse with the pixel the display scan is lighting at that moment.
- Confirms the position over several consecutive frames, then emits a single write strobe with (row, col) to the frame-RAM write path in the LED driver.
- Sits between the pen input pad, the scan-position outputs of the LED driver, and the RAM write port.

Parameters:
- LAG_CYC, 2: clk cycles of photodiode/pad latency. Scan coordinates, strobe and frame_start are delayed by this amount before correlation. Legal range 0..15.
- CONFIRM_FRAMES, 3: consecutive frames that must hit the same pixel before hit_vld. Legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  pen input enabled; high only in DRAW/WRITE/ERASE states
- pen_i  in  1  pen detect, active-high (already inverted at top), asynchronous to clk
- scan_row  in  3  row currently lit
- scan_col  in  3  column currently lit
- scan_stb  in  1  1-cycle strobe; scan_row/scan_col are valid and lit
- frame_start  in  1  1-cycle pulse coincident with the first scan_stb of a frame
- hit_vld  out  1  1-cycle confirmed-hit strobe
- hit_row  out  3  confirmed row; held until the next hit
- hit_col  out  3  confirmed column; held until the next hit
- pen_present  out  1  high while the tracker state is not IDLE

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - hit_vld=0, hit_row=0, hit_col=0, pen_present=0
  - state=IDLE, cnt=0, cand_vld=0, sync and delay registers=0
- Reset mid-frame discards the partial frame. The first frame_start after reset is only a boundary; it has no candidate, so no hit results.
- pen_i passes through a 2-flop synchronizer, giving pen_s.
- Delay line: {scan_row, scan_col, scan_stb, frame_start} delayed LAG_CYC cycles, giving d_row, d_col, d_stb, d_fs. LAG_CYC=0 means pass-through.
- Candidate capture, per frame:
  - When d_stb=1, pen_s=1 and cand_vld=0: cand={d_row,d_col}, cand_vld=1.
  - First hit in a frame wins; later hits in the same frame are ignored.
- Frame evaluation happens on d_fs=1 and uses the candidate collected before this cycle.
  - A d_stb hit in the same cycle as d_fs belongs to the new frame.
  - After evaluation, cand_vld clears; it is then set the same cycle if that simultaneous hit exists.
- State machine, evaluated only on d_fs:
  - IDLE:
    - cand_vld=1: go to TRACK, stored=cand, cnt=1.
    - If CONFIRM_FRAMES=1, go directly to LOCKED and emit.
  - TRACK, cand_vld=0: go to IDLE, cnt=0.
  - TRACK, cand==stored: cnt=cnt+1. When cnt+1==CONFIRM_FRAMES: go to LOCKED and emit.
  - TRACK, cand!=stored: stored=cand, cnt=1 (emit if CONFIRM_FRAMES=1).
  - LOCKED, cand==stored: stay; no re-emit.
  - LOCKED, cand!=stored: go to TRACK, stored=cand, cnt=1 (if CONFIRM_FRAMES=1, stay LOCKED and emit the new pixel).
  - LOCKED, cand_vld=0: go to IDLE.
- Emit:
  - hit_vld=1 for exactly the cycle after the evaluating d_fs.
  - hit_row/hit_col are updated in the same cycle.
- cnt saturates and never wraps. Width is clog2(CONFIRM_FRAMES+1).
- en=0 forces, in one cycle: state=IDLE, cand_vld=0, cnt=0, hit_vld=0. hit_row/hit_col keep their values.
- On en rising, tracking restarts at the next d_fs.
- pen_present is registered: it is 1 in TRACK and LOCKED, and follows the state with one cycle of latency.
- A stuck pen (pen_s=1 for a whole frame) hits the first strobed pixel in every frame. This is treated as a normal hit (the same pixel each frame) and is not an error.

Decomposition:
- Shared include pen_defs.v holds:
  - `define codes for PEN_IDLE, PEN_TRACK, PEN_LOCKED (2 bits)
  - the matrix coordinate width `PIX_W=3
- Sub-module scan_delay:
  - parameterised LAG_CYC shift register over 8 bits {row, col, stb, fs}
  - synchronous reset
  - LAG_CYC=0 generates wires

Test Plan:
- Basic confirm: LAG_CYC=2, CONFIRM_FRAMES=3. pen_i high only while pixel (5,2) is lit, for 3 frames → one hit_vld, 1 cycle after the 4th frame_start is delayed through scan_delay (d_fs); hit_row=5, hit_col=2; pen_present=1 from the 2nd d_fs.
- Move: after LOCKED at (5,2), pen moves to (1,7) for 3 frames → state goes TRACK and then LOCKED; one hit_vld with (1,7); no re-emit of (5,2) while held 5 more frames.
- Dropout: (3,3) hit in frames 1-2, no pen in frame 3, (3,3) again in frames 4-6 → no hit_vld until after frame 6; pen_present=0 for one evaluated frame.
- Multiple hits/boundary: pen high over (0,0) through (0,3) in one frame, repeated 3 times → hit (0,0). A pen hit coincident with d_fs is counted in the new frame.
- en/reset: en=0 mid-TRACK → pen_present=0 next cycle, no hit_vld. rst asserted mid-frame → all outputs 0; the first post-reset frame_start yields no hit.
- CONFIRM_FRAMES=1, LAG_CYC=0: hits on (2,4) then (6,6) in consecutive frames → two hit_vld pulses with those coordinates.

Source files
------------

// File: rtl/pen_locator_pkg.sv
// Shared types for the light-pen locator: tracker state codes, matrix
// coordinate width and the packed scan word carried through the lag line.
package pen_locator_pkg;

  localparam int PIX_W = 3;

  typedef enum logic [1:0] {
    PEN_IDLE   = 2'd0,
    PEN_TRACK  = 2'd1,
    PEN_LOCKED = 2'd2
  } pen_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] row;
    logic [PIX_W-1:0] col;
    logic             stb;
    logic             fs;
  } scan_word_t;

endpackage

// File: rtl/pen_locator_if.sv
// Scan-position bus from the LED driver and confirmed-hit bus to its frame RAM.
// Handshake: scan_stb qualifies scan_row/scan_col for one cycle and hit_vld
// qualifies hit_row/hit_col for one cycle; neither side can stall (no ready).
interface pen_locator_if;
  logic [pen_locator_pkg::PIX_W-1:0] scan_row;
  logic [pen_locator_pkg::PIX_W-1:0] scan_col;
  logic                              scan_stb;
  logic                              frame_start;
  logic                              hit_vld;
  logic [pen_locator_pkg::PIX_W-1:0] hit_row;
  logic [pen_locator_pkg::PIX_W-1:0] hit_col;

  modport master (
    output scan_row, scan_col, scan_stb, frame_start,
    input  hit_vld, hit_row, hit_col
  );

  modport slave (
    input  scan_row, scan_col, scan_stb, frame_start,
    output hit_vld, hit_row, hit_col
  );
endinterface

// File: rtl/pen_locator_scan_delay.sv
// Delays the scan word by LAG_CYC clocks so it lines up with the pen pad
// and synchronizer latency; LAG_CYC=0 is a straight wire.
module scan_delay
  import pen_locator_pkg::*;
#(
  parameter int unsigned LAG_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  scan_word_t d,
  output scan_word_t q
);

  generate
    if (LAG_CYC == 0) begin : g_wire
      assign q = d;
    end else begin : g_shift
      scan_word_t sr [LAG_CYC];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(LAG_CYC); i++) sr[i] <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < int'(LAG_CYC); i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[LAG_CYC-1];
    end
  endgenerate

endmodule

// File: rtl/pen_locator.sv
// Correlates the synchronized pen pulse with the lag-aligned scan position and
// emits one hit strobe once the same pixel is seen CONFIRM_FRAMES frames in a row.
module pen_locator
  import pen_locator_pkg::*;
#(
  parameter int unsigned LAG_CYC        = 2,
  parameter int unsigned CONFIRM_FRAMES = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pen_i,
  pen_locator_if.slave  bus,
  output logic          pen_present,
  output pen_state_e    dbg_state
);

  localparam int CNT_W = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                 pen_q1, pen_s;
  scan_word_t           scan_in, scan_d;
  pen_state_e           state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [2*PIX_W-1:0]   cand, stored, stored_next;
  logic                 cand_vld, emit, pen_hit;

  assign scan_in   = {bus.scan_row, bus.scan_col, bus.scan_stb, bus.frame_start};
  assign pen_hit   = scan_d.stb & pen_s;
  assign dbg_state = state;

  scan_delay #(.LAG_CYC(LAG_CYC)) u_delay (
    .clk (clk),
    .rst (rst),
    .d   (scan_in),
    .q   (scan_d)
  );

  // Frame evaluation only happens on the delayed frame boundary.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stored_next = stored;
    emit        = 1'b0;
    if (scan_d.fs) begin
      if (!cand_vld) begin
        state_next = PEN_IDLE;
        cnt_next   = '0;
      end else if (state != PEN_IDLE && cand == stored) begin
        if (state == PEN_TRACK) begin
          cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
          if (cnt_next == CNT_MAX) begin
            state_next = PEN_LOCKED;
            emit       = 1'b1;
          end
        end
      end else begin
        stored_next = cand;
        cnt_next    = CNT_ONE;
        if (CONFIRM_FRAMES == 1) begin
          state_next = PEN_LOCKED;
          emit       = 1'b1;
        end else begin
          state_next = PEN_TRACK;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= PEN_IDLE;
      cnt    <= '0;
      stored <= '0;
    end else if (!en) begin
      state  <= PEN_IDLE;
      cnt    <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      stored <= stored_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pen_q1      <= 1'b0;
      pen_s       <= 1'b0;
      cand        <= '0;
      cand_vld    <= 1'b0;
      pen_present <= 1'b0;
      bus.hit_vld <= 1'b0;
      bus.hit_row <= '0;
      bus.hit_col <= '0;
    end else begin
      pen_q1      <= pen_i;
      pen_s       <= pen_q1;
      pen_present <= (state != PEN_IDLE);
      bus.hit_vld <= 1'b0;
      if (!en) begin
        cand_vld <= 1'b0;
      end else begin
        bus.hit_vld <= emit;
        if (emit) {bus.hit_row, bus.hit_col} <= stored_next;
        // A hit coincident with the boundary seeds the new frame's candidate.
        if (scan_d.fs) begin
          cand_vld <= pen_hit;
          if (pen_hit) cand <= {scan_d.row, scan_d.col};
        end else if (pen_hit && !cand_vld) begin
          cand_vld <= 1'b1;
          cand     <= {scan_d.row, scan_d.col};
        end
      end
    end
  end

endmodule
